// File: rtl/hand_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hand_link_pkg
//  Description : Definitions shared by the hand-coordinate link packetizer and
//                the receiver-side depacketizer. Contains the packet length,
//                the default sync byte, the packetizer state encoding and the
//                packet checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
package hand_link_pkg;

    // Number of bytes in one framed packet: sync, 5 payload bytes, checksum.
    localparam int PKT_LEN = 7;

    // Default first byte of every packet.
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_DONE    = 3'd4
    } pkt_state_e;

    // XOR of payload bytes 1..5. The sync byte is excluded so the receiver
    // can validate a packet independently of the configured sync value.
    function automatic logic [7:0] calc_checksum(
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3,
        input logic [7:0] b4,
        input logic [7:0] b5
    );
        return b1 ^ b2 ^ b3 ^ b4 ^ b5;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hand_coord_packetizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : hand_coord_packetizer_if
//  Description : Byte-level UART transmitter handshake.
//                  txd_start_out : one-cycle byte start (packetizer -> tx)
//                  txd_data_out  : byte to send, stable until byte completes
//                  tx_busy_in    : transmitter busy (tx -> packetizer)
//                master modport = packetizer side, slave modport = transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hand_coord_packetizer_if;

    logic       txd_start_out;
    logic [7:0] txd_data_out;
    logic       tx_busy_in;

    modport master (
        output txd_start_out,
        output txd_data_out,
        input  tx_busy_in
    );

    modport slave (
        input  txd_start_out,
        input  txd_data_out,
        output tx_busy_in
    );

endinterface
`default_nettype wire

// File: rtl/hand_coord_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : hand_coord_packetizer
//  Description : Serialises one hand-tracking sample (x, y, z) into a framed
//                7-byte packet and feeds it byte by byte to a UART transmitter.
//                Bytes: SYNC, x[11:4], {x[3:0],y[11:8]}, y[7:0], z[13:6],
//                {z[5:0],seq[1:0]}, XOR(bytes 1..5).
//  Ports       : clk_in, rst_in (async, active-low)
//                update_in, hand_x_in, hand_y_in, hand_z_in : sample input
//                tx_if (master)  : transmitter start/data/busy handshake
//                pkt_busy_out    : packet in progress
//                pkt_done_out    : one-cycle pulse after last byte completes
//                drop_cnt_out    : saturating count of overwritten samples
//  Revision    : 1.0 - initial release
// ============================================================================
module hand_coord_packetizer
    import hand_link_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int          BUSY_WAIT = 4
) (
    input  wire logic        clk_in,
    input  wire logic        rst_in,
    input  wire logic        update_in,
    input  wire logic [11:0] hand_x_in,
    input  wire logic [11:0] hand_y_in,
    input  wire logic [13:0] hand_z_in,
    hand_coord_packetizer_if.master tx_if,
    output logic             pkt_busy_out,
    output logic             pkt_done_out,
    output logic [7:0]       drop_cnt_out
);

    localparam int              TW         = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam logic [TW-1:0]   c_wait_last = TW'(BUSY_WAIT - 1);
    localparam logic [2:0]      c_last_idx  = 3'(PKT_LEN - 1);

    pkt_state_e    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    seq_q, seq_d;
    logic [7:0]    drop_q, drop_d;
    logic          pend_valid_q, pend_valid_d;
    logic [11:0]   pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [13:0]   pend_z_q, pend_z_d;
    logic [11:0]   act_x_q, act_x_d, act_y_q, act_y_d;
    logic [13:0]   act_z_q, act_z_d;
    logic          txd_start_q, txd_start_d;
    logic [7:0]    txd_data_q, txd_data_d;
    logic          done_q, done_d;

    logic          load_act;
    logic          byte_done;
    logic [2:0]    idx_next;
    logic [7:0]    next_byte;
    logic [7:0]    csum;

    // Packet start happens exactly when IDLE sees a pending sample.
    assign load_act = (state_q == ST_IDLE) && pend_valid_q;
    assign idx_next = idx_q + 3'd1;

    // seq_q only changes in DONE, so the checksum is stable for the packet.
    assign csum = calc_checksum(act_x_q[11:4],
                                {act_x_q[3:0], act_y_q[11:8]},
                                act_y_q[7:0],
                                act_z_q[13:6],
                                {act_z_q[5:0], seq_q});

    // Byte for the index about to be started (idx 0 is loaded from IDLE).
    always_comb begin
        next_byte = 8'h00;
        case (idx_next)
            3'd1:    next_byte = act_x_q[11:4];
            3'd2:    next_byte = {act_x_q[3:0], act_y_q[11:8]};
            3'd3:    next_byte = act_y_q[7:0];
            3'd4:    next_byte = act_z_q[13:6];
            3'd5:    next_byte = {act_z_q[5:0], seq_q};
            3'd6:    next_byte = csum;
            default: next_byte = 8'h00;
        endcase
    end

    // Sample capture: pending / active registers and drop counter.
    always_comb begin
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        pend_z_d     = pend_z_q;
        pend_valid_d = pend_valid_q;
        act_x_d      = act_x_q;
        act_y_d      = act_y_q;
        act_z_d      = act_z_q;
        drop_d       = drop_q;
        if (load_act) begin
            act_x_d = pend_x_q;
            act_y_d = pend_y_q;
            act_z_d = pend_z_q;
        end
        if (update_in) begin
            pend_x_d     = hand_x_in;
            pend_y_d     = hand_y_in;
            pend_z_d     = hand_z_in;
            pend_valid_d = 1'b1;
            // A sample arriving while the old one is being copied out
            // replaces nothing, so it is not a drop.
            if (pend_valid_q && !load_act && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (load_act) begin
            pend_valid_d = 1'b0;
        end
    end

    // Packet FSM: next state and registered outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        seq_d       = seq_q;
        txd_start_d = 1'b0;
        txd_data_d  = txd_data_q;
        done_d      = 1'b0;
        byte_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    idx_d      = 3'd0;
                    txd_data_d = SYNC_BYTE;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (!tx_if.tx_busy_in) begin
                    txd_start_d = 1'b1;
                    timer_d     = '0;
                    state_d     = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                // A transmitter that never raises busy must not hang the
                // packet; after the wait window the byte is assumed sent.
                if (tx_if.tx_busy_in) begin
                    state_d = ST_WAIT_LO;
                end else if (timer_q == c_wait_last) begin
                    byte_done = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_if.tx_busy_in) begin
                    byte_done = 1'b1;
                end
            end
            ST_DONE: begin
                seq_d   = seq_q + 2'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (byte_done) begin
            if (idx_q == c_last_idx) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end else begin
                idx_d      = idx_next;
                txd_data_d = next_byte;
                state_d    = ST_START;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            timer_q      <= '0;
            seq_q        <= 2'd0;
            drop_q       <= 8'h00;
            pend_valid_q <= 1'b0;
            pend_x_q     <= 12'h000;
            pend_y_q     <= 12'h000;
            pend_z_q     <= 14'h0000;
            act_x_q      <= 12'h000;
            act_y_q      <= 12'h000;
            act_z_q      <= 14'h0000;
            txd_start_q  <= 1'b0;
            txd_data_q   <= 8'h00;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            seq_q        <= seq_d;
            drop_q       <= drop_d;
            pend_valid_q <= pend_valid_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_z_q     <= pend_z_d;
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            act_z_q      <= act_z_d;
            txd_start_q  <= txd_start_d;
            txd_data_q   <= txd_data_d;
            done_q       <= done_d;
        end
    end

    assign tx_if.txd_start_out = txd_start_q;
    assign tx_if.txd_data_out  = txd_data_q;
    assign pkt_busy_out        = (state_q != ST_IDLE);
    assign pkt_done_out        = done_q;
    assign drop_cnt_out        = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_hand_coord_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hand_coord_packetizer
//  Description : Self-checking bench for hand_coord_packetizer. A transmitter
//                model answers the start/busy handshake; every expected packet
//                byte is pushed to a scoreboard queue when the sample is driven
//                and popped when the DUT issues a start pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hand_coord_packetizer;

    localparam int BYTE_T = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        update = 1'b0;
    logic [11:0] hx = '0;
    logic [11:0] hy = '0;
    logic [13:0] hz = '0;
    logic        pkt_busy;
    logic        pkt_done;
    logic [7:0]  drop_cnt;

    hand_coord_packetizer_if tx_if ();

    hand_coord_packetizer #(
        .SYNC_BYTE (8'hA5),
        .BUSY_WAIT (4)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .update_in    (update),
        .hand_x_in    (hx),
        .hand_y_in    (hy),
        .hand_z_in    (hz),
        .tx_if        (tx_if),
        .pkt_busy_out (pkt_busy),
        .pkt_done_out (pkt_done),
        .drop_cnt_out (drop_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb_q[$];
    logic [1:0]  exp_seq = 2'd0;
    int          start_cnt = 0;
    int          done_cnt = 0;
    int          rx_idx = 0;
    logic [7:0]  rx_pkt[7];
    logic [7:0]  last_byte = 8'h00;
    bit          stable_ok = 1'b0;
    int          tx_mode = 1;     // 0 normal, 1 busy tied low, 2 busy stuck high
    int          busy_cnt = 0;

    initial tx_if.tx_busy_in = 1'b0;

    // Monitor + scoreboard consumer + transmitter model, all on negedge.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (!rst_n) begin
            rx_idx    = 0;
            stable_ok = 1'b0;
        end else begin
            if (tx_if.txd_start_out) begin
                start_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_byte: got unexpected byte %02h, required none", tx_if.txd_data_out);
                end else begin
                    exp_b = sb_q.pop_front();
                    if (tx_if.txd_data_out !== exp_b) begin
                        errors++;
                        $display("FAIL sb_byte[%0d]: got %02h, required %02h", rx_idx, tx_if.txd_data_out, exp_b);
                    end
                end
                if (rx_idx < 7) rx_pkt[rx_idx] = tx_if.txd_data_out;
                rx_idx++;
                last_byte = tx_if.txd_data_out;
                stable_ok = 1'b1;
            end else if (tx_if.tx_busy_in && stable_ok) begin
                checks++;
                if (tx_if.txd_data_out !== last_byte) begin
                    errors++;
                    $display("FAIL data_stable: got %02h, required %02h", tx_if.txd_data_out, last_byte);
                end
            end
            if (pkt_done) begin
                done_cnt++;
                rx_idx    = 0;
                stable_ok = 1'b0;
            end
        end

        case (tx_mode)
            0: begin
                if (tx_if.txd_start_out && rst_n) begin
                    busy_cnt = BYTE_T;
                    tx_if.tx_busy_in = 1'b1;
                end else if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) tx_if.tx_busy_in = 1'b0;
                end else begin
                    tx_if.tx_busy_in = 1'b0;
                end
            end
            2: tx_if.tx_busy_in = 1'b1;
            default: begin
                busy_cnt = 0;
                tx_if.tx_busy_in = 1'b0;
            end
        endcase
    end

    task automatic push_packet(input logic [11:0] x, input logic [11:0] y, input logic [13:0] z);
        logic [7:0] b[7];
        b[0] = 8'hA5;
        b[1] = x[11:4];
        b[2] = {x[3:0], y[11:8]};
        b[3] = y[7:0];
        b[4] = z[13:6];
        b[5] = {z[5:0], exp_seq};
        b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        for (int i = 0; i < 7; i++) sb_q.push_back(b[i]);
        exp_seq = exp_seq + 2'd1;
    endtask

    task automatic send_update(input logic [11:0] x, input logic [11:0] y, input logic [13:0] z);
        @(negedge clk);
        update = 1'b1;
        hx = x;
        hy = y;
        hz = z;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk);
            #1;
            if (pkt_done === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: pkt_done got none within %0d cycles, required a pulse", name, budget);
        end
    endtask

    task automatic do_reset();
        tx_mode = 1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        exp_seq = 2'd0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_if.txd_start_out, tx_if.txd_data_out, pkt_busy, pkt_done, drop_cnt} !== 19'h0) begin
            errors++;
            $display("FAIL reset_vals: got start=%b data=%02h busy=%b done=%b drop=%0d, required all 0",
                     tx_if.txd_start_out, tx_if.txd_data_out, pkt_busy, pkt_done, drop_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pkt_busy !== 1'b0 || tx_if.txd_start_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b start=%b, required 0 0", pkt_busy, tx_if.txd_start_out);
        end
    endtask

    task automatic test_single();
        int d0;
        tx_mode = 0;
        d0 = done_cnt;
        push_packet(12'hABC, 12'h123, 14'h3FFF);
        @(negedge clk);
        update = 1'b1;
        hx = 12'hABC;
        hy = 12'h123;
        hz = 14'h3FFF;
        @(posedge clk);          // edge t: sample captured
        #1 update = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (pkt_busy !== 1'b1 || tx_if.txd_start_out !== 1'b0 || tx_if.txd_data_out !== 8'hA5) begin
            errors++;
            $display("FAIL start_t1: got busy=%b start=%b data=%02h, required 1 0 a5",
                     pkt_busy, tx_if.txd_start_out, tx_if.txd_data_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (tx_if.txd_start_out !== 1'b1 || tx_if.txd_data_out !== 8'hA5) begin
            errors++;
            $display("FAIL start_t2: got start=%b data=%02h, required 1 a5", tx_if.txd_start_out, tx_if.txd_data_out);
        end
        wait_done("single_done", 400);
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || rx_pkt[6] !== (8'hAB ^ 8'hC1 ^ 8'h23 ^ 8'hFF ^ 8'hFC)) begin
            errors++;
            $display("FAIL single_pkt: got done pulses=%0d csum=%02h, required 1 %02h",
                     done_cnt - d0, rx_pkt[6], 8'hAB ^ 8'hC1 ^ 8'h23 ^ 8'hFF ^ 8'hFC);
        end
    endtask

    task automatic test_overwrite();
        tx_mode = 0;
        push_packet(12'h111, 12'h222, 14'h0333);
        send_update(12'h111, 12'h222, 14'h0333);
        // This pulse lands on the pending->active copy edge: it becomes
        // pending without being counted as a drop.
        send_update(12'h444, 12'h555, 14'h0666);
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL drop_copy_edge: got %0d, required 0", drop_cnt);
        end
        send_update(12'h777, 12'h888, 14'h0999);
        checks++;
        if (drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL drop_2nd: got %0d, required 1", drop_cnt);
        end
        push_packet(12'hDEF, 12'h0F1, 14'h2A5C);
        send_update(12'hDEF, 12'h0F1, 14'h2A5C);
        checks++;
        if (drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL drop_3rd: got %0d, required 2", drop_cnt);
        end
        wait_done("overwrite_done1", 400);
        wait_done("overwrite_done2", 400);
    endtask

    task automatic test_timeout();
        int s0;
        int n;
        bit got;
        tx_mode = 1;
        s0 = start_cnt;
        push_packet(12'h5A5, 12'hA5A, 14'h1234);
        @(negedge clk);
        update = 1'b1;
        hx = 12'h5A5;
        hy = 12'hA5A;
        hz = 14'h1234;
        @(posedge clk);
        #1 update = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (pkt_done === 1'b1) got = 1'b1;
        end
        // 1 START + 4 wait cycles per byte, 7 bytes, plus the first IDLE cycle.
        checks++;
        if (!got || n != 36) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles (done=%b), required 36", n, got);
        end
        @(negedge clk);
        checks++;
        if (start_cnt - s0 != 7) begin
            errors++;
            $display("FAIL timeout_starts: got %0d, required 7", start_cnt - s0);
        end
    endtask

    task automatic test_stall();
        int s0;
        bit bad;
        tx_mode = 2;
        @(negedge clk);
        s0 = start_cnt;
        push_packet(12'h0C3, 12'h3C0, 14'h3001);
        send_update(12'h0C3, 12'h3C0, 14'h3001);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_if.txd_start_out !== 1'b0 || tx_if.txd_data_out !== 8'hA5 || pkt_busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad || start_cnt != s0) begin
            errors++;
            $display("FAIL stall_hold: got starts=%0d data=%02h, required 0 a5", start_cnt - s0, tx_if.txd_data_out);
        end
        tx_mode = 0;
        wait_done("stall_done", 400);
    endtask

    task automatic test_reset_mid();
        int s0;
        bit got;
        tx_mode = 0;
        s0 = start_cnt;
        push_packet(12'h321, 12'h654, 14'h0987);
        send_update(12'h321, 12'h654, 14'h0987);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (start_cnt - s0 >= 4) got = 1'b1;
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (!got || {tx_if.txd_start_out, tx_if.txd_data_out, pkt_busy, pkt_done, drop_cnt} !== 19'h0) begin
            errors++;
            $display("FAIL reset_async: got reached=%b start=%b data=%02h busy=%b done=%b drop=%0d, required 1 and all 0",
                     got, tx_if.txd_start_out, tx_if.txd_data_out, pkt_busy, pkt_done, drop_cnt);
        end
        tx_mode = 1;
        sb_q.delete();
        exp_seq = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tx_mode = 0;
        push_packet(12'h0AA, 12'h055, 14'h1FC3);
        send_update(12'h0AA, 12'h055, 14'h1FC3);
        wait_done("reset_fresh_done", 400);
        @(negedge clk);
        checks++;
        if (rx_pkt[0] !== 8'hA5 || rx_pkt[5][1:0] !== 2'd0) begin
            errors++;
            $display("FAIL reset_fresh: got byte0=%02h seq=%0d, required a5 0", rx_pkt[0], rx_pkt[5][1:0]);
        end
    endtask

    task automatic test_wrap_sat();
        logic [1:0] want;
        do_reset();
        tx_mode = 0;
        for (int k = 0; k < 5; k++) begin
            want = exp_seq;
            push_packet(12'(k * 257 + 3), 12'(k * 113 + 9), 14'(k * 3001 + 7));
            send_update(12'(k * 257 + 3), 12'(k * 113 + 9), 14'(k * 3001 + 7));
            wait_done("wrap_done", 400);
            @(negedge clk);
            checks++;
            if (rx_pkt[5][1:0] !== want) begin
                errors++;
                $display("FAIL wrap_seq[%0d]: got %0d, required %0d", k, rx_pkt[5][1:0], want);
            end
        end
        checks++;
        if (rx_pkt[5][1:0] !== 2'b00) begin
            errors++;
            $display("FAIL wrap_5th: got %0d, required 0", rx_pkt[5][1:0]);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d bytes, required 0", sb_q.size());
        end

        // Saturation: park a packet in START, then keep overwriting pending.
        tx_mode = 2;
        send_update(12'h001, 12'h002, 14'h0003);
        repeat (3) @(negedge clk);
        update = 1'b1;
        for (int i = 1; i <= 301; i++) begin
            @(posedge clk);
            #1;
            if (i == 101 || i == 256 || i == 301) begin
                checks++;
                if (drop_cnt !== ((i - 1 > 255) ? 8'd255 : 8'(i - 1))) begin
                    errors++;
                    $display("FAIL drop_sat[%0d]: got %0d, required %0d", i, drop_cnt, (i - 1 > 255) ? 255 : i - 1);
                end
            end
        end
        update = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_overwrite();
        test_timeout();
        test_stall();
        test_reset_mid();
        test_wrap_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/hand_coord_packetizer.md
# hand_coord_packetizer

Serialises one hand-tracking sample (bottom-left x, y, z) into a fixed 7-byte framed packet. It drives the byte-level UART transmitter's start/data/busy handshake. It sits between the camera pipeline's coordinate outputs (captured on its transmit-update pulse) and the transmitter, and carries the second camera's hand position to the first board.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, first byte of every packet
- BUSY_WAIT, 4, cycles to wait for tx_busy_in to rise after a start pulse before the byte counts as sent

Ports:
- clk_in  input  1  system clock (65 MHz domain)
- rst_in  input  1  reset; asynchronous assert, active-low
- update_in  input  1  one-cycle pulse: coordinates valid, send a packet
- hand_x_in  input  12  hand x
- hand_y_in  input  12  hand y
- hand_z_in  input  14  hand z
- tx_busy_in  input  1  transmitter busy
- txd_start_out  output  1  one-cycle byte start to transmitter
- txd_data_out  output  8  byte to transmit; held stable from start until the byte completes
- pkt_busy_out  output  1  packet in progress
- pkt_done_out  output  1  one-cycle pulse after the last byte completes
- drop_cnt_out  output  8  saturating count of overwritten pending samples

## Operation
Packet byte order, indices 0..6:
- 0: SYNC_BYTE
- 1: x[11:4]
- 2: {x[3:0], y[11:8]}
- 3: y[7:0]
- 4: z[13:6]
- 5: {z[5:0], seq[1:0]}
- 6: XOR of bytes 1..5

seq behaviour:
- 2-bit counter, reset 0.
- Increments on each pkt_done_out, wraps 3→0.

Sample capture:
- update_in high: x/y/z are snapshotted into a pending register and pend_valid is set.
- Packet start: pending is copied to the active register and pend_valid is cleared.
- update_in while pend_valid is already set: pending is overwritten with the newest sample and drop_cnt_out increments, saturating at 255.
- update_in in the same cycle as the pending→active copy: the new sample becomes pending, and it is not counted as a drop.

FSM states: IDLE, START, WAIT_HI, WAIT_LO, DONE.
- IDLE: if pend_valid, load active, set idx=0, go to START.
- START: if tx_busy_in low, assert txd_start_out for one cycle and go to WAIT_HI. Otherwise stay, with txd_start_out low.
- WAIT_HI: on tx_busy_in high go to WAIT_LO. After BUSY_WAIT cycles without it, treat the byte as done.
- WAIT_LO: on tx_busy_in low:
  - idx<6: increment idx, go to START.
  - idx=6: go to DONE.
- DONE: pulse pkt_done_out, increment seq, go to IDLE.

Output and reset behaviour:
- pkt_busy_out is high in every state except IDLE.
- Reset values: state IDLE, txd_start_out 0, txd_data_out 8'h00, pkt_busy_out 0, pkt_done_out 0, drop_cnt_out 0, seq 0, pend_valid 0.
- Reset mid-packet aborts immediately. There is no partial resume; the receiver resyncs on SYNC_BYTE.

## Timing
- update_in at edge t in IDLE: START in cycle t+1. txd_start_out is high in cycle t+2 at the earliest, if tx_busy_in is low.
- txd_data_out is registered. It changes only on entry to START, so it is valid in the same cycle as txd_start_out.
- The checksum is computed combinationally from the active register. It is stable for the whole packet.
- Back-to-back packets: with pend_valid set at DONE, the next packet reaches START 2 cycles after DONE (DONE→IDLE→START).
- Minimum packet length is 7×(byte time + 3) cycles.

## Structure
- Shared package hand_link_pkg:
  - PKT_LEN = 7
  - default SYNC_BYTE
  - state enum type
  - checksum function, XOR over bytes 1..5
- The receiver-side depacketizer reuses this package.
- No sub-module. Capture, FSM and byte mux stay in one module.

## Test plan
1. Single packet: x=12'hABC, y=12'h123, z=14'h3FFF, model transmitter (busy 1 cycle after start, for 20 cycles). Required bytes A5, AB, C1, 23, FF, FC, then checksum 8'hAB^C1^23^FF^FC. One pkt_done_out pulse.
2. Overwrite: three update_in pulses during a packet. drop_cnt_out=1 after the 2nd and 2 after the 3rd. The next packet carries the 3rd sample; seq increments 0→1.
3. Busy timeout: tx_busy_in tied low. Each byte is issued after BUSY_WAIT cycles. 7 start pulses, then pkt_done_out.
4. Transmitter stall: tx_busy_in held high at START for 50 cycles. No txd_start_out occurs until it drops, and txd_data_out stays stable.
5. Reset mid-packet at byte 3: all outputs return to reset values asynchronously. After release, a fresh update sends a packet starting with A5, seq=0.
6. Wrap and saturation: 4 packets give seq 0,1,2,3, and the 5th packet's byte 5 low bits read 00. 300 drops give drop_cnt_out=255.
